// File: rtl/dds_pkg.sv
// Shared definitions for the multi-channel DDS oscillator: waveform and FSM
// encodings plus the phase-to-waveform helpers used by the shaping stage.
// Latency: n/a (types and pure functions). Backpressure: n/a.
package dds_pkg;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_SAW    = 2'd2,
        MODE_TRI    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Sawtooth: flipping the MSB maps phase 0 to the most negative code.
    // Operates on the low w bits of a 32-bit container (w <= 32).
    function automatic logic [31:0] saw_wave(input logic [31:0] p, input int w);
        return p ^ (32'd1 << (w - 1));
    endfunction

    // Triangle: fold the second half of the period, double, then re-centre.
    function automatic logic [31:0] tri_wave(input logic [31:0] p, input int w);
        logic [31:0] mask;
        logic [31:0] t;
        mask = (32'd1 << w) - 32'd1;
        t    = p[w - 1] ? ~p : p;
        t    = (t << 1) & mask;
        return t ^ (32'd1 << (w - 1));
    endfunction

endpackage

// File: rtl/dds_wave_rom.sv
// One-period sine table, 2^ADDR_W x DATA_W, registered read.
// Latency: 1 cycle from addr_i to data_o. Backpressure: none, reads every cycle.
// Ports: clk, addr_i (table index), data_o (signed sample, two's complement).
module dds_wave_rom #(
    parameter int    ADDR_W    = 10,
    parameter int    DATA_W    = 16,
    parameter string INIT_FILE = "sintable.mif"
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int HALF  = DEPTH / 2;

    // Carried into the elaborated design so the vendor init attribute and
    // the instance parameter stay in step.
    localparam string INIT_FILE_unused = INIT_FILE;

    // Default contents from a rational sine approximation (Bhaskara I),
    // exact at 0, +/-full scale and the zero crossings; a vendor flow can
    // replace them from INIT_FILE.
    function automatic logic [DATA_W-1:0] sine_at(input int idx);
        longint full;
        longint t;
        longint q;
        longint num;
        longint den;
        longint v;
        full = (longint'(1) << (DATA_W - 1)) - 1;
        t    = longint'(idx % HALF);
        q    = t * (longint'(HALF) - t);
        num  = 16 * q;
        den  = 5 * longint'(HALF) * longint'(HALF) - 4 * q;
        v    = (full * num) / den;
        if (idx >= HALF) begin
            v = -v;
        end
        return DATA_W'(v);
    endfunction

    (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
        assign rom[i] = sine_at(i);
    end

    always_ff @(posedge clk) begin
        data_o <= rom[addr_i];
    end

endmodule

// File: rtl/dds_multi_osc.sv
// Multi-channel DDS: one round-robin sweep of NUM_CH phase accumulators per
// sample_tick, shared sine ROM, waveform shaping and amplitude scaling.
// Latency: tick at T -> ch0 at T+3, last channel at T+2+NUM_CH. No backpressure;
// a tick while busy is dropped and flagged on overrun.
// Ports: clk/reset (sync, active high), sample_tick, packed per-channel ch_en/
// step/mode/amp (ch0 in LSBs); out_valid/out_ch/out_data stream, sweep_done, overrun.
module dds_multi_osc
    import dds_pkg::*;
#(
    parameter int    NUM_CH    = 4,
    parameter int    ACC_W     = 16,
    parameter int    ADDR_W    = 10,
    parameter int    DATA_W    = 16,
    parameter int    AMP_W     = 8,
    parameter string INIT_FILE = "sintable.mif"
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          sample_tick,
    input  logic [NUM_CH-1:0]                             ch_en,
    input  logic [NUM_CH*ACC_W-1:0]                       step,
    input  logic [NUM_CH*2-1:0]                           mode,
    input  logic [NUM_CH*AMP_W-1:0]                       amp,
    output logic                                          out_valid,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
    output logic [DATA_W-1:0]                             out_data,
    output logic                                          sweep_done,
    output logic                                          overrun
);

    localparam int              CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int              PW        = DATA_W + AMP_W + 1;
    localparam logic [CH_W-1:0] LAST_SLOT = CH_W'(NUM_CH - 1);
    localparam logic [DATA_W-1:0] POS_FS  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_FS  = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};

    // ---------------- sweep control ----------------
    state_e          state_q;
    logic [CH_W-1:0] slot_q;
    logic            drain_q;
    logic            overrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            drain_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= sample_tick && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (sample_tick) begin
                        state_q <= RUN;
                        slot_q  <= '0;
                    end
                end
                RUN: begin
                    if (slot_q == LAST_SLOT) begin
                        state_q <= DRAIN;
                        drain_q <= 1'b0;
                    end else begin
                        slot_q <= slot_q + 1'b1;
                    end
                end
                DRAIN: begin
                    // Two cycles: ROM read and shaping stage empty out.
                    if (drain_q) begin
                        state_q <= IDLE;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ---------------- slot stage (S) ----------------
    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic              slot_vld;
    logic [ACC_W-1:0]  acc_cur;
    logic [ACC_W-1:0]  step_cur;
    logic [ACC_W-1:0]  acc_d;
    logic [1:0]        mode_cur;
    logic [AMP_W-1:0]  amp_cur;
    logic              en_cur;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    assign slot_vld = (state_q == RUN);
    assign acc_cur  = acc_q[slot_q];
    assign step_cur = step[slot_q*ACC_W +: ACC_W];
    assign mode_cur = mode[slot_q*2 +: 2];
    assign amp_cur  = amp[slot_q*AMP_W +: AMP_W];
    assign en_cur   = ch_en[slot_q];
    assign rom_addr = acc_cur[ACC_W-1 -: ADDR_W];
    // A disabled channel restarts from phase 0 when it is re-enabled.
    assign acc_d    = en_cur ? acc_cur + step_cur : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
        end else if (slot_vld) begin
            acc_q[slot_q] <= acc_d;
        end
    end

    dds_wave_rom #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clk    (clk),
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    // Slot attributes ride alongside the ROM read.
    logic              s1_vld_q;
    logic              s1_last_q;
    logic [CH_W-1:0]   s1_ch_q;
    mode_e             s1_mode_q;
    logic [AMP_W-1:0]  s1_amp_q;
    logic              s1_en_q;
    logic [DATA_W-1:0] s1_ph_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_ch_q   <= '0;
            s1_mode_q <= MODE_SINE;
            s1_amp_q  <= '0;
            s1_en_q   <= 1'b0;
            s1_ph_q   <= '0;
        end else begin
            s1_vld_q <= slot_vld;
            if (slot_vld) begin
                s1_last_q <= (slot_q == LAST_SLOT);
                s1_ch_q   <= slot_q;
                s1_mode_q <= mode_e'(mode_cur);
                s1_amp_q  <= amp_cur;
                s1_en_q   <= en_cur;
                s1_ph_q   <= acc_cur[ACC_W-1 -: DATA_W];
            end
        end
    end

    // ---------------- shaping + scaling (S+1) ----------------
    logic [DATA_W-1:0]    wave;
    logic signed [PW-1:0] prod;
    logic [DATA_W-1:0]    scaled;
    logic                 prod_unused;

    always_comb begin
        wave = rom_data;
        case (s1_mode_q)
            MODE_SINE:   wave = rom_data;
            MODE_SQUARE: wave = s1_ph_q[DATA_W-1] ? NEG_FS : POS_FS;
            MODE_SAW:    wave = DATA_W'(saw_wave(32'(s1_ph_q), DATA_W));
            MODE_TRI:    wave = DATA_W'(tri_wave(32'(s1_ph_q), DATA_W));
            default:     wave = rom_data;
        endcase
    end

    // Amp is unsigned, so it gets a zero sign bit before the signed multiply;
    // taking bits [AMP_W +: DATA_W] is the arithmetic shift plus truncation.
    assign prod        = PW'($signed(wave)) * PW'($signed({1'b0, s1_amp_q}));
    assign scaled      = s1_en_q ? prod[AMP_W +: DATA_W] : '0;
    assign prod_unused = ^{prod[AMP_W-1:0], prod[PW-1]};

    logic              out_valid_q;
    logic [CH_W-1:0]   out_ch_q;
    logic [DATA_W-1:0] out_data_q;
    logic              sweep_done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_data_q   <= '0;
            sweep_done_q <= 1'b0;
        end else begin
            out_valid_q  <= s1_vld_q;
            sweep_done_q <= s1_vld_q && s1_last_q;
            if (s1_vld_q) begin
                out_ch_q   <= s1_ch_q;
                out_data_q <= scaled;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign out_data   = out_data_q;
    assign sweep_done = sweep_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_dds_multi_osc.sv
// Scoreboard bench for dds_multi_osc: a reference model predicts each sweep
// when the tick is driven; a negedge monitor pops and compares outputs.
// Latency and sweep_done position are checked per sample.
module tb_dds_multi_osc;

    localparam int  NCH    = 4;
    localparam real TWO_PI = 6.283185307179586;
    localparam int  TOL    = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic [3:0]  ch_en = '0;
    logic [63:0] step = '0;
    logic [7:0]  mode = '0;
    logic [31:0] amp = '0;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [15:0] out_data;
    logic        sweep_done;
    logic        overrun;

    dds_multi_osc #(
        .NUM_CH(NCH), .ACC_W(16), .ADDR_W(10), .DATA_W(16), .AMP_W(8),
        .INIT_FILE("sintable.mif")
    ) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .ch_en(ch_en),
        .step(step), .mode(mode), .amp(amp), .out_valid(out_valid),
        .out_ch(out_ch), .out_data(out_data), .sweep_done(sweep_done),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int data;
        int cyc;
        bit approx;
        bit last;
    } exp_t;

    exp_t sb_q[$];
    int   m_acc [NCH];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   ovr_cnt = 0;
    int   pk = -100000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_ch(input int c, input bit en, input int st, input int md, input int am);
        ch_en[c]         = en;
        step[c*16 +: 16] = 16'(st);
        mode[c*2 +: 2]   = 2'(md);
        amp[c*8 +: 8]    = 8'(am);
    endtask

    // Reference model of one sweep; inputs are held stable for the sweep.
    task automatic push_sweep(input int t);
        exp_t e;
        int   p, w, a, addr;
        bit   apx;
        real  r;
        for (int c = 0; c < NCH; c++) begin
            p   = m_acc[c];
            a   = int'(amp[c*8 +: 8]);
            apx = 1'b0;
            w   = 0;
            case (mode[c*2 +: 2])
                2'd0: begin
                    addr = p >> 6;
                    if (addr % 256 == 0) begin
                        w = (addr == 256) ? 32767 : (addr == 768) ? -32767 : 0;
                    end else begin
                        r   = 32767.0 * $sin(TWO_PI * addr / 1024.0);
                        w   = $rtoi((r >= 0.0) ? r + 0.5 : r - 0.5);
                        apx = 1'b1;
                    end
                end
                2'd1: w = (p >= 32768) ? -32767 : 32767;
                2'd2: w = p - 32768;
                default: w = (p < 32768) ? 2 * p - 32768 : 2 * (65535 - p) - 32768;
            endcase
            e.ch     = c;
            e.data   = ch_en[c] ? ((w * a) >>> 8) : 0;
            e.approx = ch_en[c] && apx;
            e.cyc    = t + 3 + c;
            e.last   = (c == NCH - 1);
            sb_q.push_back(e);
            m_acc[c] = ch_en[c] ? ((p + int'(step[c*16 +: 16])) & 16'hFFFF) : 0;
        end
    endtask

    task automatic do_tick();
        @(posedge clk); #1;
        push_sweep(cyc);
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
    endtask

    // gap = NCH+1 gives the minimum legal tick spacing with the next do_tick.
    task automatic run_ticks(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            do_tick();
            repeat (gap) @(posedge clk);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   d;
        if (overrun) ovr_cnt++;
        if (out_valid) begin
            d = int'($signed(out_data));
            if (out_ch == 2'd0 && d > pk) pk = d;
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("out_ch", int'(out_ch), e.ch);
                check("out_cycle", cyc, e.cyc);
                check("sweep_done", int'(sweep_done), int'(e.last));
                if (e.approx)
                    check("sine_tol", ((d - e.data <= TOL) && (e.data - d <= TOL)) ? e.data : d, e.data);
                else
                    check("out_data", d, e.data);
            end
        end else if (sweep_done) begin
            check("stray_sweep_done", 1, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov0;
        for (int c = 0; c < NCH; c++) m_acc[c] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", int'(out_valid), 0);
        check("rst_done", int'(sweep_done), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_ch", int'(out_ch), 0);
        check("rst_data", int'(out_data), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: all enabled, step 0, sine, full amplitude.
        for (int c = 0; c < NCH; c++) set_ch(c, 1, 0, 0, 255);
        run_ticks(1, NCH + 1);

        // 2: ch0 sweeps the table; peak at quarter period.
        set_ch(0, 1, 16'h0400, 0, 128);
        for (int c = 1; c < NCH; c++) set_ch(c, 1, 0, 0, 0);
        pk = -100000;
        run_ticks(256, NCH + 1);
        check("sine_peak", pk, 16383);

        // 3: ch1 at phase 0x4000 through square/saw/triangle.
        set_ch(1, 1, 16'h4000, 1, 255);
        run_ticks(1, NCH + 2);
        set_ch(1, 1, 0, 1, 255);
        run_ticks(1, NCH + 2);
        set_ch(1, 1, 0, 2, 255);
        run_ticks(1, NCH + 2);
        set_ch(1, 1, 0, 3, 255);
        run_ticks(1, NCH + 2);

        // 4: tick two cycles into a sweep is dropped.
        set_ch(0, 1, 16'h1000, 2, 255);
        set_ch(1, 1, 16'h2000, 1, 200);
        set_ch(2, 1, 16'h0C00, 3, 100);
        set_ch(3, 1, 16'h0800, 2, 7);
        ov0 = ovr_cnt;
        do_tick();
        @(posedge clk); #1;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        repeat (NCH + 2) @(posedge clk);
        check("overrun_once", ovr_cnt - ov0, 1);
        run_ticks(2, NCH + 1);

        // 5: ch2 disabled for one sweep, then restarts from phase 0.
        set_ch(2, 1, 16'h1000, 2, 200);
        run_ticks(2, NCH + 1);
        ch_en[2] = 1'b0;
        run_ticks(1, NCH + 1);
        ch_en[2] = 1'b1;
        run_ticks(2, NCH + 1);

        // 6: reset during slot 1 flushes the sweep.
        for (int c = 0; c < NCH; c++) set_ch(c, 1, 16'h1000 * (c + 1), 2, 255);
        run_ticks(1, NCH + 1);
        do_tick();
        @(posedge clk); #1;
        reset = 1'b1;
        sb_q.delete();
        for (int c = 0; c < NCH; c++) m_acc[c] = 0;
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_data", int'(out_data), 0);
        check("post_rst_ch", int'(out_ch), 0);
        repeat (4) @(posedge clk);
        run_ticks(2, NCH + 1);

        repeat (10) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        check("overrun_total", ovr_cnt, 1);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
